bot_update_reader: RTL and testbench
====================================

Name: bot_update_reader

Overview:
- Consumer end of the Rojobot update handshake.
- The bot-update handshake flop raises an update-sync level. This block detects it, snapshots the 32-bit bot info word {LocX, LocY, Sensors, BotInfo} into a small FIFO, and drives the interrupt-acknowledge that clears the flop.
- Replaces firmware polling of the update-sync GPIO. The core pops snapshots through a first-word-fall-through read port.

Parameters:
- FIFO_DEPTH, 4, number of snapshot entries; power of two, 2..16.
- SYNC_STAGES, 2, synchronizer flops on i_botupdt_sync; minimum 2.
- ACK_TIMEOUT, 1024, cycles ACK may wait for sync to drop before abandoning; 0 disables the timeout.

Ports:
- clk  in  1  block clock.
- rst  in  1  synchronous, active-high reset.
- i_botupdt_sync  in  1  update-pending level from the handshake flop.
- i_botinfo  in  32  {LocX[31:24], LocY[23:16], Sensors[15:8], BotInfo[7:0]}.
- o_int_ack  out  1  acknowledge level back to the handshake flop.
- o_rd_valid  out  1  FIFO head valid.
- o_rd_data  out  32  FIFO head snapshot.
- i_rd_en  in  1  pop head; ignored when o_rd_valid=0.
- o_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- o_overflow  out  1  sticky: a snapshot was dropped because the FIFO was full.
- o_ack_err  out  1  sticky: an ACK timeout occurred.
- i_clr_err  in  1  clears o_overflow and o_ack_err.

Behaviour:
- Reset (sync, active-high):
  - State=IDLE.
  - o_int_ack=0, o_rd_valid=0, o_rd_data=0, o_count=0, o_overflow=0, o_ack_err=0.
  - Synchronizer flops cleared; FIFO pointers zeroed.
  - Reset mid-ACK drops the ACK on the next edge. A pending sync is re-detected after reset.
- Synchronization: i_botupdt_sync passes through SYNC_STAGES flops to give sync_s. i_botinfo is not synchronized; it is sampled only in CAPTURE.
- FSM (all outputs registered):
  - IDLE: o_int_ack=0. If sync_s=1, go to CAPTURE.
  - CAPTURE (exactly 1 cycle): push i_botinfo.
    - If the FIFO is full and i_rd_en&o_rd_valid is not asserted the same cycle, drop the word and set o_overflow.
    - Go to ACK; o_int_ack=1 from the next edge.
  - ACK: hold o_int_ack=1.
    - If sync_s=0, go to IDLE; o_int_ack=0 from the next edge.
    - If ACK_TIMEOUT!=0 and the wait counter reaches ACK_TIMEOUT-1, set o_ack_err and go to IDLE.
  - There is no re-capture until sync_s has been seen low in ACK, or the timeout has fired. One capture per handshake.
- Latency: first edge sampling i_botupdt_sync=1 is edge k. Then:
  - sync_s=1 after edge k+SYNC_STAGES-1.
  - CAPTURE after edge k+SYNC_STAGES.
  - FIFO write and o_int_ack=1 after edge k+SYNC_STAGES+1.
- FIFO (FWFT):
  - Written entry appears on o_rd_data/o_rd_valid after the write edge when empty.
  - Pop advances the head on the same edge.
  - Simultaneous push and pop: when full, both accepted and count unchanged; when empty, the pushed word becomes head and o_rd_valid=1.
  - Pointers wrap modulo FIFO_DEPTH. o_count is exact, 0..FIFO_DEPTH.
- Sticky flags: set has priority over i_clr_err in the same cycle.
- Wait counter: cleared on entry to ACK; width $clog2(ACK_TIMEOUT+1).

Optional Feature:
- BOT_UPDATE_READER_DEDUP_EN
  - Defined: in CAPTURE, a snapshot equal to the last word pushed since reset is not pushed. ACK proceeds normally and no overflow is flagged. The last-pushed register resets to 0; a first snapshot of 0 is still pushed, using a valid bit.
  - Undefined: every capture is pushed.

Decomposition:
- Package bot_update_pkg:
  - state enum {IDLE, CAPTURE, ACK} as 2-bit logic.
  - Field localparams for the LocX/LocY/Sensors/BotInfo bit positions.
  - typedef for the bot info word.
- Sub-module bot_snap_fifo: parameterized FWFT FIFO with count, instantiated once.

Test Plan:
- Single handshake: SYNC_STAGES=2, i_botinfo=32'h1234_5678, raise sync at edge 10 → CAPTURE at 12, o_int_ack=1 after 13, o_rd_data=32'h12345678, o_count=1. Drop sync at edge 20 → o_int_ack=0 after edge 22.
- Overflow: 5 handshakes with no pops, FIFO_DEPTH=4 → o_count=4, o_overflow=1, head still the first word. i_clr_err → o_overflow=0.
- Full with same-cycle pop: FIFO full while a capture coincides with i_rd_en → count stays 4, new word at the tail, o_overflow=0.
- Timeout: ACK_TIMEOUT=16, sync held high → o_ack_err=1 and IDLE after 16 ACK cycles, then a new capture occurs (count+1).
- Reset mid-ACK: assert rst during ACK → o_int_ack=0, count=0 next edge. Sync still high → recaptured SYNC_STAGES+1 edges after rst falls.
- Dedup (macro defined): two handshakes with an identical 32'hA5A5_0001 → count=1, both acked. A third handshake with 32'hA5A5_0002 → count=2.

Source files
------------

// File: rtl/bot_update_reader_pkg.sv
// bot_update_pkg: shared types and constants for the Rojobot update reader.
//   state_t     - reader FSM states (IDLE, CAPTURE, ACK), 2-bit encoding
//   *_LSB       - bit positions of the 8-bit fields inside the bot info word
//   bot_info_t  - the 32-bit {LocX, LocY, Sensors, BotInfo} snapshot word
package bot_update_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } state_t;

    localparam int INFO_W      = 32;
    localparam int FIELD_W     = 8;
    localparam int LOCX_LSB    = 24;
    localparam int LOCY_LSB    = 16;
    localparam int SENSORS_LSB = 8;
    localparam int BOTINFO_LSB = 0;

    typedef logic [INFO_W-1:0] bot_info_t;

endpackage

// File: rtl/bot_update_reader_fifo.sv
// bot_snap_fifo: first-word-fall-through snapshot FIFO with exact occupancy.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   wr_en     - push request; accepted when not full, or when full and a pop
//               happens on the same edge
//   wr_data   - word to push
//   rd_en     - pop request; ignored while empty
//   rd_valid  - head entry valid
//   rd_data   - head entry (shows the written word right after the write edge)
//   count     - entries held, 0..DEPTH
//   full      - count == DEPTH
module bot_snap_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             pop;
    logic             push;

    assign full     = (cnt == CW'(DEPTH));
    assign rd_valid = (cnt != '0);
    assign rd_data  = mem[rd_ptr];
    assign count    = cnt;

    // A pop frees the slot the push needs, so full+pop+push is legal.
    assign pop  = rd_en && rd_valid;
    assign push = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/bot_update_reader.sv
// bot_update_reader: consumer end of the Rojobot update handshake.
// Detects the update-sync level, snapshots the bot info word into a FWFT
// FIFO once per handshake and raises int_ack until the sync level drops
// (or an optional timeout abandons the wait).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_botupdt_sync  - update-pending level from the handshake flop (async)
//   i_botinfo       - {LocX, LocY, Sensors, BotInfo}, sampled only in CAPTURE
//   o_int_ack       - acknowledge level back to the handshake flop
//   o_rd_valid      - FIFO head valid
//   o_rd_data       - FIFO head snapshot
//   i_rd_en         - pop head
//   o_count         - entries held
//   o_overflow      - sticky, a snapshot was dropped on a full FIFO
//   o_ack_err       - sticky, an ACK timeout occurred
//   i_clr_err       - clears both sticky flags (a same-cycle set wins)
// Optional build macro: BOT_UPDATE_READER_DEDUP_EN - skip pushing a snapshot
// identical to the last word pushed since reset.
module bot_update_reader
    import bot_update_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_botupdt_sync,
    input  logic [31:0]                   i_botinfo,
    output logic                          o_int_ack,
    output logic                          o_rd_valid,
    output logic [31:0]                   o_rd_data,
    input  logic                          i_rd_en,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow,
    output logic                          o_ack_err,
    input  logic                          i_clr_err
);
    localparam int WAIT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic TIMEOUT_EN = (ACK_TIMEOUT != 0);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_s;
    state_t                 state;
    logic [WAIT_W-1:0]      wait_cnt;
    bot_info_t              snap_word;
    logic                   fifo_full;
    logic                   pop;
    logic                   dup;
    logic                   push_req;
    logic                   drop;
    logic                   timeout_hit;

    assign sync_s = sync_ff[SYNC_STAGES-1];

    // Field-wise assembly documents the word layout; bits are not reordered.
    assign snap_word = {i_botinfo[LOCX_LSB +: FIELD_W], i_botinfo[LOCY_LSB +: FIELD_W],
                        i_botinfo[SENSORS_LSB +: FIELD_W], i_botinfo[BOTINFO_LSB +: FIELD_W]};

    assign pop         = i_rd_en && o_rd_valid;
    assign push_req    = (state == CAPTURE) && !dup;
    assign drop        = push_req && fifo_full && !pop;
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);

`ifdef BOT_UPDATE_READER_DEDUP_EN
    // last_valid lets a first snapshot of zero through.
    logic      last_valid;
    bot_info_t last_word;

    assign dup = last_valid && (snap_word == last_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid <= 1'b0;
            last_word  <= '0;
        end else if (push_req && !drop) begin
            last_valid <= 1'b1;
            last_word  <= snap_word;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], i_botupdt_sync};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            o_int_ack <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_int_ack <= 1'b0;
                    if (sync_s) state <= CAPTURE;
                end
                CAPTURE: begin
                    state     <= ACK;
                    o_int_ack <= 1'b1;
                    wait_cnt  <= '0;
                end
                ACK: begin
                    // Sync dropping takes precedence over a same-cycle timeout.
                    if (!sync_s || timeout_hit) begin
                        state     <= IDLE;
                        o_int_ack <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_int_ack <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_overflow <= 1'b0;
            o_ack_err  <= 1'b0;
        end else begin
            if (drop)           o_overflow <= 1'b1;
            else if (i_clr_err) o_overflow <= 1'b0;
            if (state == ACK && sync_s && timeout_hit) o_ack_err <= 1'b1;
            else if (i_clr_err)                       o_ack_err <= 1'b0;
        end
    end

    bot_snap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INFO_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push_req),
        .wr_data  (snap_word),
        .rd_en    (i_rd_en),
        .rd_valid (o_rd_valid),
        .rd_data  (o_rd_data),
        .count    (o_count),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_bot_update_reader.sv
// Self-checking bench for bot_update_reader (FIFO_DEPTH=4, SYNC_STAGES=2,
// ACK_TIMEOUT=16). A handshake-level model predicts every output each cycle;
// directed sequences add literal expectations at known edges.
module tb_bot_update_reader;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync;
    logic [31:0] botinfo;
    logic        int_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_en;
    logic [2:0]  count;
    logic        overflow;
    logic        ack_err;
    logic        clr_err;

    int vectors     = 0;
    int miscompares = 0;

    bot_update_reader #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SS),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_botupdt_sync (sync),
        .i_botinfo      (botinfo),
        .o_int_ack      (int_ack),
        .o_rd_valid     (rd_valid),
        .o_rd_data      (rd_data),
        .i_rd_en        (rd_en),
        .o_count        (count),
        .o_overflow     (overflow),
        .o_ack_err      (ack_err),
        .i_clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Handshake view: the sync level is seen SS edges late; a seen level in
    // idle schedules one capture, after which ack is held until the seen
    // level drops or TO ack cycles elapse.
    logic [31:0] exp_q[$];
    logic [63:0] hist   = '0;
    bit          m_on   = 0;
    bit          m_cap  = 0;
    bit          m_ack  = 0;
    int          m_wait = 0;
    bit          m_ovf  = 0;
    bit          m_err  = 0;
    bit          m_last_v = 0;
    logic [31:0] m_last = '0;

    always @(posedge clk) begin
        bit s, pop, do_push, ovf_set, err_set;
        if (rst) begin
            exp_q.delete();
            hist = '0; m_cap = 0; m_ack = 0; m_wait = 0;
            m_ovf = 0; m_err = 0; m_last_v = 0; m_last = '0;
            m_on = 1;
        end else begin
            s = hist[SS-1];
            pop = rd_en && (exp_q.size() > 0);
            do_push = 0; ovf_set = 0; err_set = 0;
            if (m_cap) begin
                do_push = 1;
`ifdef BOT_UPDATE_READER_DEDUP_EN
                if (m_last_v && botinfo == m_last) do_push = 0;
`endif
                if (do_push && exp_q.size() == DEPTH && !pop) begin
                    do_push = 0;
                    ovf_set = 1;
                end
                m_cap = 0; m_ack = 1; m_wait = 0;
            end else if (m_ack) begin
                if (!s) m_ack = 0;
                else if (m_wait == TO - 1) begin m_ack = 0; err_set = 1; end
                else m_wait++;
            end else if (s) begin
                m_cap = 1;
            end
            if (pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(botinfo);
                m_last = botinfo;
                m_last_v = 1;
            end
            m_ovf = ovf_set ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
            m_err = err_set ? 1'b1 : (clr_err ? 1'b0 : m_err);
            hist = {hist[62:0], sync};
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_on) begin
            check("m_ack", 32'(int_ack), 32'(m_ack));
            check("m_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
            check("m_count", 32'(count), 32'(exp_q.size()));
            check("m_overflow", 32'(overflow), 32'(m_ovf));
            check("m_ack_err", 32'(ack_err), 32'(m_err));
            if (exp_q.size() != 0) check("m_head", rd_data, exp_q[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (int_ack !== lvl && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(int_ack), 32'(lvl));
    endtask

    task automatic handshake(input logic [31:0] d);
        botinfo = d;
        sync = 1'b1;
        wait_ack(1'b1, "hs_ack_up");
        sync = 1'b0;
        wait_ack(1'b0, "hs_ack_down");
        @(negedge clk);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w [6];
        rst = 1'b1; sync = 1'b0; botinfo = '0; rd_en = 1'b0; clr_err = 1'b0;
        for (int i = 0; i < 6; i++) w[i] = 32'hC0DE_0000 | 32'(i);

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(int_ack), 32'h0);
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_data", rd_data, 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_err", 32'(ack_err), 32'h0);
        rst = 1'b0;

        // single handshake with exact latency: sync first sampled at edge k
        botinfo = 32'h1234_5678;
        sync = 1'b1;
        repeat (3) @(negedge clk);                 // after k+2 (CAPTURE)
        check("t1_ack_k2", 32'(int_ack), 32'h0);
        check("t1_cnt_k2", 32'(count), 32'h0);
        @(negedge clk);                            // after k+3
        check("t1_ack_k3", 32'(int_ack), 32'h1);
        check("t1_data", rd_data, 32'h1234_5678);
        check("t1_count", 32'(count), 32'h1);
        sync = 1'b0;                               // drop first sampled at edge j
        repeat (2) @(negedge clk);                 // after j+1
        check("t1_ack_j1", 32'(int_ack), 32'h1);
        @(negedge clk);                            // after j+2
        check("t1_ack_j2", 32'(int_ack), 32'h0);
        pop_one();
        check("t1_pop_count", 32'(count), 32'h0);
        pop_one();                                 // pop on empty is ignored
        check("empty_pop_count", 32'(count), 32'h0);
        check("empty_pop_valid", 32'(rd_valid), 32'h0);

        // overflow: five handshakes, no pops
        reset_dut();
        for (int i = 0; i < 5; i++) handshake(w[i]);
        check("ovf_count", 32'(count), 32'h4);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_head", rd_data, 32'hC0DE_0000);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("ovf_clr", 32'(overflow), 32'h0);

        // full FIFO, capture coincides with a pop
        botinfo = w[5];
        sync = 1'b1;
        repeat (3) @(negedge clk);                 // CAPTURE cycle now
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("fp_count", 32'(count), 32'h4);
        check("fp_ovf", 32'(overflow), 32'h0);
        check("fp_head", rd_data, 32'hC0DE_0001);
        sync = 1'b0;
        wait_ack(1'b0, "fp_ack_down");
        check("fp_pop1", rd_data, 32'hC0DE_0001); pop_one();
        check("fp_pop2", rd_data, 32'hC0DE_0002); pop_one();
        check("fp_pop3", rd_data, 32'hC0DE_0003); pop_one();
        check("fp_pop4", rd_data, 32'hC0DE_0005); pop_one();
        check("fp_empty", 32'(count), 32'h0);

        // ack timeout with sync held high
        reset_dut();
        botinfo = 32'hDEAD_BEEF;
        sync = 1'b1;
        repeat (19) @(negedge clk);                // after k+18
        check("to_ack_hold", 32'(int_ack), 32'h1);
        check("to_err_early", 32'(ack_err), 32'h0);
        @(negedge clk);                            // after k+19
        check("to_ack_drop", 32'(int_ack), 32'h0);
        check("to_err", 32'(ack_err), 32'h1);
        check("to_count1", 32'(count), 32'h1);
        repeat (2) @(negedge clk);                 // after k+21: recapture
        check("to_recap_ack", 32'(int_ack), 32'h1);
        check("to_count2", 32'(count), 32'h2);
        sync = 1'b0;
        wait_ack(1'b0, "to_ack_down");
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("to_err_clr", 32'(ack_err), 32'h0);

        // reset during ACK with sync still high
        reset_dut();
        botinfo = 32'h0BAD_F00D;
        sync = 1'b1;
        wait_ack(1'b1, "rm_ack_up");
        rst = 1'b1;
        @(negedge clk);
        check("rm_ack", 32'(int_ack), 32'h0);
        check("rm_count", 32'(count), 32'h0);
        check("rm_valid", 32'(rd_valid), 32'h0);
        rst = 1'b0;                                // first clean edge e
        repeat (3) @(negedge clk);                 // after e+2
        check("rm_cnt_e2", 32'(count), 32'h0);
        @(negedge clk);                            // after e+3
        check("rm_recap_ack", 32'(int_ack), 32'h1);
        check("rm_recap_cnt", 32'(count), 32'h1);
        check("rm_recap_data", rd_data, 32'h0BAD_F00D);
        sync = 1'b0;
        wait_ack(1'b0, "rm_ack_down");

`ifdef BOT_UPDATE_READER_DEDUP_EN
        reset_dut();
        handshake(32'hA5A5_0001);
        handshake(32'hA5A5_0001);
        check("dd_count1", 32'(count), 32'h1);
        handshake(32'hA5A5_0002);
        check("dd_count2", 32'(count), 32'h2);
        check("dd_ovf", 32'(overflow), 32'h0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
